reg_user_seq: RTL and testbench

REG_USER_SEQ -- requirements
Module: reg_user_seq

---
 rtl/genius_pkg.sv | 14 +
 rtl/seq_cmp.sv | 28 ++
 rtl/reg_user_seq.sv | 110 +++++++++++
 tb/tb_reg_user_seq.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/genius_pkg.sv
// Shared definitions for the genius game: sequence FSM states and default
// entry geometry used by the player-sequence register and its peers.
package genius_pkg;

    localparam int GENIUS_ENTRY_W = 4;
    localparam int GENIUS_DEPTH   = 16;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DONE    = 2'd1,
        FAIL    = 2'd2
    } seq_state_t;

endpackage

// File: rtl/seq_cmp.sv
// Selects one slot of the packed reference sequence and compares it with the
// incoming player entry. Purely combinational.
module seq_cmp #(
    parameter int ENTRY_W = 4,
    parameter int DEPTH   = 16,
    parameter int IW      = 4
) (
    input  logic [ENTRY_W-1:0]       din,
    input  logic [ENTRY_W*DEPTH-1:0] ref_data,
    input  logic [IW-1:0]            idx,
    output logic                     match
);

    logic [ENTRY_W-1:0] ref_slot;

    // An index past the last slot selects zero rather than wrapping.
    always_comb begin
        ref_slot = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (idx == IW'(i)) begin
                ref_slot = ref_data[i*ENTRY_W +: ENTRY_W];
            end
        end
    end

    assign match = (din == ref_slot);

endmodule

// File: rtl/reg_user_seq.sv
// Player sequence register: collects entries one per strobe, checks each
// against the expected sequence and reports round completion or first error.
module reg_user_seq
    import genius_pkg::*;
#(
    parameter int ENTRY_W = GENIUS_ENTRY_W,
    parameter int DEPTH   = GENIUS_DEPTH,
    parameter int CW      = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     R,
    input  logic                     E,
    input  logic                     clr,
    input  logic [ENTRY_W-1:0]       din,
    input  logic [ENTRY_W*DEPTH-1:0] ref_data,
    input  logic [CW-1:0]            level,
    output logic [ENTRY_W*DEPTH-1:0] q,
    output logic [CW-1:0]            count,
    output logic                     full,
    output logic                     done,
    output logic                     err,
    output logic [CW-1:0]            err_idx
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    seq_state_t         state;
    seq_state_t         next_state;
    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [CW-1:0]      eff_level;
    logic [CW-1:0]      next_count;
    logic [IW-1:0]      slot_idx;
    logic               accept;
    logic               match;

    assign full       = (count == CW'(DEPTH));
    assign slot_idx   = count[IW-1:0];
    assign next_count = count + CW'(1);
    assign accept     = (state == COLLECT) && E && !clr && !full;
    assign done       = (state == DONE);
    assign err        = (state == FAIL);

    // Out-of-range or zero level means "fill the whole buffer".
    always_comb begin
        eff_level = level;
        if (level == '0 || level > CW'(DEPTH)) begin
            eff_level = CW'(DEPTH);
        end
    end

    seq_cmp #(
        .ENTRY_W (ENTRY_W),
        .DEPTH   (DEPTH),
        .IW      (IW)
    ) u_seq_cmp (
        .din      (din),
        .ref_data (ref_data),
        .idx      (slot_idx),
        .match    (match)
    );

    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            state <= COLLECT;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (clr) begin
            next_state = COLLECT;
        end else if (accept) begin
            if (!match) begin
                next_state = FAIL;
            end else if (next_count == eff_level) begin
                next_state = DONE;
            end
        end
    end

    // A mismatching entry is still stored and counted; err_idx keeps its slot.
    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            count   <= '0;
            err_idx <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clr) begin
            count   <= '0;
            err_idx <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (accept) begin
            mem[slot_idx] <= din;
            count         <= next_count;
            if (!match) begin
                err_idx <= count;
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_pack
        assign q[g*ENTRY_W +: ENTRY_W] = mem[g];
    end

endmodule

// File: tb/tb_reg_user_seq.sv
// Self-checking bench for reg_user_seq: a reference model pushes expected
// outputs to a scoreboard queue as stimulus is driven; they are popped after the edge.
module tb_reg_user_seq;

    localparam int EW = 4;
    localparam int DP = 16;
    localparam int CW = 5;

    typedef struct {
        logic [EW*DP-1:0] q;
        logic [CW-1:0]    count;
        logic             full;
        logic             done;
        logic             err;
        logic [CW-1:0]    err_idx;
    } exp_t;

    logic              clk = 1'b0;
    logic              R   = 1'b0;
    logic              E   = 1'b0;
    logic              clr = 1'b0;
    logic [EW-1:0]     din = '0;
    logic [EW*DP-1:0]  ref_data = '0;
    logic [CW-1:0]     level = '0;
    logic [EW*DP-1:0]  q;
    logic [CW-1:0]     count;
    logic              full;
    logic              done;
    logic              err;
    logic [CW-1:0]     err_idx;

    int check_count = 0;
    int pass_count  = 0;

    // Reference model state
    logic [EW-1:0] ref_mem [DP];
    logic [EW-1:0] mq [DP];
    int            mcount;
    int            merr_idx;
    int            mstate;
    exp_t          sb [$];

    reg_user_seq #(.ENTRY_W(EW), .DEPTH(DP), .CW(CW)) dut (
        .clk      (clk),
        .R        (R),
        .E        (E),
        .clr      (clr),
        .din      (din),
        .ref_data (ref_data),
        .level    (level),
        .q        (q),
        .count    (count),
        .full     (full),
        .done     (done),
        .err      (err),
        .err_idx  (err_idx)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        check_count++;
        if (obs === exp) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_ref();
        for (int i = 0; i < DP; i++) begin
            ref_data[i*EW +: EW] = ref_mem[i];
        end
    endtask

    task automatic model_reset();
        mstate   = 0;
        mcount   = 0;
        merr_idx = 0;
        for (int i = 0; i < DP; i++) mq[i] = '0;
    endtask

    // States: 0 collecting, 1 round complete, 2 round failed.
    task automatic model_step(input logic e, input logic c, input logic [EW-1:0] d);
        int eff;
        eff = (level == 0 || int'(level) > DP) ? DP : int'(level);
        if (c) begin
            model_reset();
        end else if (mstate == 0 && e && mcount != DP) begin
            mq[mcount] = d;
            mcount++;
            if (d != ref_mem[mcount-1]) begin
                mstate   = 2;
                merr_idx = mcount - 1;
            end else if (mcount == eff) begin
                mstate = 1;
            end
        end
    endtask

    function automatic exp_t model_expect();
        exp_t x;
        for (int i = 0; i < DP; i++) x.q[i*EW +: EW] = mq[i];
        x.count   = CW'(mcount);
        x.full    = (mcount == DP);
        x.done    = (mstate == 1);
        x.err     = (mstate == 2);
        x.err_idx = CW'(merr_idx);
        return x;
    endfunction

    task automatic apply_stimulus(input string tag, input logic e, input logic c, input logic [EW-1:0] d);
        exp_t x;
        @(negedge clk);
        E = e; clr = c; din = d;
        model_step(e, c, d);
        sb.push_back(model_expect());
        @(posedge clk);
        #1;
        x = sb.pop_front();
        check_output({tag, ".q"},       64'(q),       64'(x.q));
        check_output({tag, ".count"},   64'(count),   64'(x.count));
        check_output({tag, ".full"},    64'(full),    64'(x.full));
        check_output({tag, ".done"},    64'(done),    64'(x.done));
        check_output({tag, ".err"},     64'(err),     64'(x.err));
        check_output({tag, ".err_idx"}, 64'(err_idx), 64'(x.err_idx));
    endtask

    initial begin
        for (int i = 0; i < DP; i++) ref_mem[i] = EW'(i + 1);
        set_ref();
        model_reset();

        // Reset held with append strobe active
        R = 1'b1; E = 1'b1; din = 4'h1; level = 5'd3;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_output("rst.q",     64'(q),     64'h0);
            check_output("rst.count", 64'(count), 64'h0);
            check_output("rst.done",  64'(done),  64'h0);
            check_output("rst.err",   64'(err),   64'h0);
        end
        @(negedge clk);
        R = 1'b0; E = 1'b0;
        apply_stimulus("idle0", 1'b0, 1'b0, 4'h1);
        apply_stimulus("idle1", 1'b0, 1'b0, 4'h2);

        // Match round, level 3
        ref_mem[0] = 4'h1; ref_mem[1] = 4'h2; ref_mem[2] = 4'h3;
        set_ref();
        level = 5'd3;
        apply_stimulus("m0", 1'b1, 1'b0, 4'h1);
        apply_stimulus("m1", 1'b1, 1'b0, 4'h2);
        apply_stimulus("m2", 1'b1, 1'b0, 4'h3);
        check_output("match.count", 64'(count), 64'd3);
        check_output("match.done",  64'(done),  64'd1);
        check_output("match.q",     64'(q[11:0]), 64'h321);
        apply_stimulus("m_ign", 1'b1, 1'b0, 4'h4);

        // Clear from DONE
        apply_stimulus("clr_done", 1'b0, 1'b1, 4'h0);
        check_output("clr_done.q", 64'(q), 64'h0);

        // Mismatch at slot 1
        apply_stimulus("x0", 1'b1, 1'b0, 4'h1);
        apply_stimulus("x1", 1'b1, 1'b0, 4'h5);
        check_output("mis.err",     64'(err),     64'd1);
        check_output("mis.err_idx", 64'(err_idx), 64'd1);
        check_output("mis.count",   64'(count),   64'd2);
        apply_stimulus("x_ign", 1'b1, 1'b0, 4'h3);
        check_output("mis.hold", 64'(count), 64'd2);

        // clr and E together: entry dropped
        apply_stimulus("coll", 1'b1, 1'b1, 4'h1);
        check_output("coll.count", 64'(count), 64'd0);
        apply_stimulus("coll_next", 1'b1, 1'b0, 4'h1);

        // Full boundary with level 0 and distinct reference values
        for (int i = 0; i < DP; i++) ref_mem[i] = EW'(i) ^ 4'hA;
        set_ref();
        level = 5'd0;
        apply_stimulus("fclr", 1'b0, 1'b1, 4'h0);
        for (int i = 0; i < DP; i++) begin
            apply_stimulus($sformatf("f%0d", i), 1'b1, 1'b0, EW'(i) ^ 4'hA);
        end
        check_output("full.done", 64'(done), 64'd1);
        check_output("full.full", 64'(full), 64'd1);
        apply_stimulus("f16", 1'b1, 1'b0, 4'h0);

        // Level lowered mid-round: buffer fills without completion, then E ignored
        level = 5'd16;
        apply_stimulus("lclr", 1'b0, 1'b1, 4'h0);
        for (int i = 0; i < 5; i++) begin
            apply_stimulus($sformatf("l%0d", i), 1'b1, 1'b0, EW'(i) ^ 4'hA);
        end
        level = 5'd2;
        for (int i = 5; i < DP; i++) begin
            apply_stimulus($sformatf("l%0d", i), 1'b1, 1'b0, EW'(i) ^ 4'hA);
        end
        check_output("lvl.full", 64'(full), 64'd1);
        check_output("lvl.done", 64'(done), 64'd0);
        apply_stimulus("l_ign", 1'b1, 1'b0, 4'h7);

        // Asynchronous reset pulse mid-round
        level = 5'd3;
        apply_stimulus("aclr", 1'b0, 1'b1, 4'h0);
        apply_stimulus("a0", 1'b1, 1'b0, 4'hA);
        apply_stimulus("a1", 1'b1, 1'b0, 4'hB);
        #2;
        R = 1'b1; E = 1'b0;
        #3;
        R = 1'b0;
        check_output("arst.count", 64'(count), 64'd0);
        check_output("arst.q",     64'(q),     64'h0);
        model_reset();
        apply_stimulus("apost", 1'b0, 1'b0, 4'h0);
        apply_stimulus("a_new", 1'b1, 1'b0, 4'hA);

        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
